sap_output_port: RTL and testbench

SAP_OUTPUT_PORT -- requirements
Module: sap_output_port

---
 rtl/sap_output_port_pkg.sv | 15 +
 rtl/sap_bit_timer.sv | 40 ++++
 rtl/sap_output_port.sv | 102 ++++++++++
 tb/tb_sap_output_port.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sap_output_port_pkg.sv
// Shared types and constants for the SAP output port: FSM state encoding,
// frame geometry and the default bit period.
package sap_output_port_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   localparam int FRAME_BITS           = 8;
   localparam int CLKS_PER_BIT_DEFAULT = 4;

endpackage

// File: rtl/sap_bit_timer.sv
// Bit-period timer: counts clocks within one serial bit and emits a single
// cycle tick on the last clock of each bit period.
module sap_bit_timer
   import sap_output_port_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic tick_o
);

   localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

   logic [7:0] cnt_q, cnt_d;

   assign tick_o = enable_i && (cnt_q == LAST_CNT);

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = 8'd0;
      end else if (enable_i) begin
         cnt_d = tick_o ? 8'd0 : cnt_q + 8'd1;
      end
   end

   // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sap_output_port.sv
// SAP output port: latches a byte from the W-bus on a load in IDLE and
// serialises it as start bit, 8 data bits LSB first, and stop bit.
module sap_output_port
   import sap_output_port_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic       inCLK,
   input  logic       inReset,
   input  logic [7:0] inBus,
   input  logic       inLoad,
   output logic [7:0] outData,
   output logic       outSerial,
   output logic       outReady,
   output logic       outDone
);

   state_e     state_q, state_d;
   logic [7:0] data_q, data_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_q, bit_d;
   logic       done_q, done_d;
   logic       accept;
   logic       tick;

   assign accept = (state_q == IDLE) && inLoad;

   sap_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk_i    (inCLK),
      .reset_i  (inReset),
      .clear_i  (accept),
      .enable_i (state_q != IDLE),
      .tick_o   (tick)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (inLoad) begin
               data_d  = inBus;
               shift_d = inBus;
               bit_d   = 3'd0;
               state_d = START;
            end
         end
         START: begin
            if (tick) state_d = DATA;
         end
         DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'(FRAME_BITS - 1)) state_d = STOP;
            end
         end
         STOP: begin
            if (tick) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge inCLK) begin
      if (inReset) begin
         state_q <= IDLE;
         data_q  <= 8'h00;
         shift_q <= 8'h00;
         bit_q   <= 3'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      outSerial = 1'b1;
      case (state_q)
         START:   outSerial = 1'b0;
         DATA:    outSerial = shift_q[0];
         default: outSerial = 1'b1;
      endcase
   end

   assign outData  = data_q;
   assign outReady = (state_q == IDLE);
   assign outDone  = done_q;

endmodule

// File: tb/tb_sap_output_port.sv
// Directed bench for sap_output_port at CLKS_PER_BIT=4 and CLKS_PER_BIT=1.
module tb_sap_output_port;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] bus4, bus1;
   logic       load4, load1;
   logic [7:0] data4, data1;
   logic       ser4, ser1, rdy4, rdy1, done4, done1;

   always #5 clk = ~clk;

   sap_output_port #(.CLKS_PER_BIT(4)) dut4 (
      .inCLK     (clk),
      .inReset   (rst),
      .inBus     (bus4),
      .inLoad    (load4),
      .outData   (data4),
      .outSerial (ser4),
      .outReady  (rdy4),
      .outDone   (done4)
   );

   sap_output_port #(.CLKS_PER_BIT(1)) dut1 (
      .inCLK     (clk),
      .inReset   (rst),
      .inBus     (bus1),
      .inLoad    (load1),
      .outData   (data1),
      .outSerial (ser1),
      .outReady  (rdy1),
      .outDone   (done1)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs are driven and outputs sampled on the falling edge, away from the active edge.
   task automatic step();
      @(negedge clk);
   endtask

   function automatic logic slot_bit(input logic [7:0] d, input int s);
      logic [7:0] v;
      v = d;
      if (s == 0) return 1'b0;
      if (s == 9) return 1'b1;
      return v[s-1];
   endfunction

   // Entered at the falling edge just after the load edge; leaves in the outDone cycle.
   task automatic run_frame(input bit u1, input logic [7:0] d, input int n, input bit busy);
      for (int j = 0; j < 10 * n; j++) begin
         check($sformatf("serial%0d[%0h] j=%0d", n, d, j), u1 ? ser1 : ser4, slot_bit(d, j / n));
         check($sformatf("done%0d j=%0d", n, j), u1 ? done1 : done4, 1'b0);
         check($sformatf("ready%0d j=%0d", n, j), u1 ? rdy1 : rdy4, 1'b0);
         check($sformatf("data%0d j=%0d", n, j), u1 ? data1 : data4, d);
         if (busy && j == 5) begin
            load4 = 1'b1;
            bus4  = 8'h3C;
         end
         if (busy && j == 12) begin
            load4 = 1'b0;
            bus4  = 8'h00;
         end
         step();
      end
      check($sformatf("done%0d end[%0h]", n, d), u1 ? done1 : done4, 1'b1);
      check($sformatf("ready%0d end[%0h]", n, d), u1 ? rdy1 : rdy4, 1'b1);
      check($sformatf("serial%0d end[%0h]", n, d), u1 ? ser1 : ser4, 1'b1);
   endtask

   initial begin
      rst   = 1'b1;
      bus4  = 8'h00;
      bus1  = 8'h00;
      load4 = 1'b0;
      load1 = 1'b0;
      step();
      step();
      rst = 1'b0;

      // Reset then idle
      for (int i = 0; i < 20; i++) begin
         check("idle data", data4, 8'h00);
         check("idle serial", ser4, 1'b1);
         check("idle ready", rdy4, 1'b1);
         check("idle done", done4, 1'b0);
         step();
      end
      check("idle1 ready", rdy1, 1'b1);
      check("idle1 serial", ser1, 1'b1);

      // Reset wins over a simultaneous load
      bus4  = 8'h5A;
      load4 = 1'b1;
      rst   = 1'b1;
      step();
      rst   = 1'b0;
      load4 = 1'b0;
      check("rstprio data", data4, 8'h00);
      step();
      check("rstprio ready", rdy4, 1'b1);
      check("rstprio serial", ser4, 1'b1);

      // Single frame with a rejected load injected mid-frame
      bus4  = 8'hA5;
      load4 = 1'b1;
      step();
      load4 = 1'b0;
      bus4  = 8'h00;
      run_frame(1'b0, 8'hA5, 4, 1'b1);
      step();
      check("post A5 done", done4, 1'b0);
      check("post A5 data", data4, 8'hA5);

      // Back-to-back: inLoad held high across the outDone cycle
      bus4  = 8'h01;
      load4 = 1'b1;
      step();
      bus4 = 8'hFF;
      run_frame(1'b0, 8'h01, 4, 1'b0);
      step();
      load4 = 1'b0;
      run_frame(1'b0, 8'hFF, 4, 1'b0);
      step();

      // Mid-frame reset at cycle 15 of the frame
      bus4  = 8'h00;
      load4 = 1'b1;
      step();
      load4 = 1'b0;
      check("mid start serial", ser4, 1'b0);
      repeat (14) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid rst serial", ser4, 1'b1);
      check("mid rst data", data4, 8'h00);
      check("mid rst ready", rdy4, 1'b1);
      for (int i = 0; i < 50; i++) begin
         check($sformatf("mid no done i=%0d", i), done4, 1'b0);
         check($sformatf("mid serial i=%0d", i), ser4, 1'b1);
         step();
      end

      // One clock per bit
      bus1  = 8'h80;
      load1 = 1'b1;
      step();
      load1 = 1'b0;
      run_frame(1'b1, 8'h80, 1, 1'b0);
      step();
      check("post 80 done", done1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
